cpu_bus_bridge: RTL and testbench

Bus bridge between the Z80-compatible CPU core and the on-chip peripherals. It detects CPU memory and I/O cycles and turns each into single-cycle strobes for the downstream slaves: the boot ROM at 0x0000–0x03FF and the 8-bit I/O space. It holds the CPU in wait until read data arrives, then drives the captured data back to the CPU. All CPU signals are synchronous to `clk`.

---
 rtl/cpu_bus_bridge.sv | 195 +++++++++++++++++++
 tb/tb_cpu_bus_bridge.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_bridge.sv
// Bridge from the Z80-style CPU bus to the boot ROM and the 8-bit I/O space.
// Every accepted CPU cycle becomes one registered strobe; the CPU is held in wait until read data is captured.
module cpu_bus_bridge #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_n_mreq,
    input  logic        cpu_n_iorq,
    input  logic        cpu_n_m1,
    input  logic        cpu_n_rd,
    input  logic        cpu_n_wr,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rdata_en,
    output logic        cpu_n_wait,
    output logic        rom_n_cs,
    output logic        rom_n_rd,
    output logic [9:0]  rom_address,
    input  logic [7:0]  rom_rdata,
    input  logic        rom_rdata_en,
    output logic        io_n_cs,
    output logic        io_n_rd,
    output logic        io_n_wr,
    output logic [7:0]  io_address,
    output logic [7:0]  io_wdata,
    input  logic [7:0]  io_rdata,
    input  logic        io_rdata_en
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ROM_RD,
        IO_RD,
        DATA_WAIT,
        HOLD,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               armed_q, armed_d;
    logic               rom_n_cs_q, rom_n_cs_d, rom_n_rd_q, rom_n_rd_d;
    logic [9:0]         rom_address_q, rom_address_d;
    logic               io_n_cs_q, io_n_cs_d, io_n_rd_q, io_n_rd_d, io_n_wr_q, io_n_wr_d;
    logic [7:0]         io_address_q, io_address_d, io_wdata_q, io_wdata_d;
    logic [7:0]         cpu_rdata_q, cpu_rdata_d;
    logic               cpu_rdata_en_q, cpu_rdata_en_d;
    logic               cpu_n_wait_q, cpu_n_wait_d;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            armed_q        <= 1'b0;
            rom_n_cs_q     <= 1'b1;
            rom_n_rd_q     <= 1'b1;
            rom_address_q  <= '0;
            io_n_cs_q      <= 1'b1;
            io_n_rd_q      <= 1'b1;
            io_n_wr_q      <= 1'b1;
            io_address_q   <= '0;
            io_wdata_q     <= '0;
            cpu_rdata_q    <= '0;
            cpu_rdata_en_q <= 1'b0;
            cpu_n_wait_q   <= 1'b1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            armed_q        <= armed_d;
            rom_n_cs_q     <= rom_n_cs_d;
            rom_n_rd_q     <= rom_n_rd_d;
            rom_address_q  <= rom_address_d;
            io_n_cs_q      <= io_n_cs_d;
            io_n_rd_q      <= io_n_rd_d;
            io_n_wr_q      <= io_n_wr_d;
            io_address_q   <= io_address_d;
            io_wdata_q     <= io_wdata_d;
            cpu_rdata_q    <= cpu_rdata_d;
            cpu_rdata_en_q <= cpu_rdata_en_d;
            cpu_n_wait_q   <= cpu_n_wait_d;
        end
    end

    // Cycle decode, slave handshake and CPU wait generation
    always_comb begin
        state_d        = state_q;
        cnt_d          = '0;
        armed_d        = armed_q | (cpu_n_rd & cpu_n_wr);
        rom_n_cs_d     = 1'b1;
        rom_n_rd_d     = 1'b1;
        rom_address_d  = rom_address_q;
        io_n_cs_d      = 1'b1;
        io_n_rd_d      = 1'b1;
        io_n_wr_d      = 1'b1;
        io_address_d   = io_address_q;
        io_wdata_d     = io_wdata_q;
        cpu_rdata_d    = cpu_rdata_q;
        cpu_rdata_en_d = 1'b0;
        cpu_n_wait_d   = 1'b1;

        case (state_q)
            IDLE: begin
                // A cycle already in flight at reset release is skipped until the bus goes idle once
                if (armed_q) begin
                    if (!cpu_n_iorq && !cpu_n_m1) begin
                        cpu_rdata_d    = 8'hFF;
                        cpu_rdata_en_d = 1'b1;
                        state_d        = HOLD;
                    end else if (!cpu_n_iorq && !cpu_n_rd) begin
                        io_n_cs_d    = 1'b0;
                        io_n_rd_d    = 1'b0;
                        io_address_d = cpu_address[7:0];
                        cpu_n_wait_d = 1'b0;
                        state_d      = IO_RD;
                    end else if (!cpu_n_iorq && !cpu_n_wr) begin
                        io_n_cs_d    = 1'b0;
                        io_n_wr_d    = 1'b0;
                        io_address_d = cpu_address[7:0];
                        io_wdata_d   = cpu_wdata;
                        state_d      = DONE;
                    end else if (!cpu_n_mreq && !cpu_n_rd) begin
                        if (cpu_address[15:10] == 6'd0) begin
                            rom_n_cs_d    = 1'b0;
                            rom_n_rd_d    = 1'b0;
                            rom_address_d = cpu_address[9:0];
                            cpu_n_wait_d  = 1'b0;
                            state_d       = ROM_RD;
                        end else begin
                            cpu_rdata_d    = 8'hFF;
                            cpu_rdata_en_d = 1'b1;
                            state_d        = HOLD;
                        end
                    end else if (!cpu_n_mreq && !cpu_n_wr) begin
                        state_d = DONE;
                    end
                end
            end
            ROM_RD, IO_RD: begin
                cpu_n_wait_d = 1'b0;
                state_d      = DATA_WAIT;
            end
            DATA_WAIT: begin
                if (rom_rdata_en) begin
                    cpu_rdata_d    = rom_rdata;
                    cpu_rdata_en_d = 1'b1;
                    state_d        = HOLD;
                end else if (io_rdata_en) begin
                    cpu_rdata_d    = io_rdata;
                    cpu_rdata_en_d = 1'b1;
                    state_d        = HOLD;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    cpu_rdata_d    = 8'hFF;
                    cpu_rdata_en_d = 1'b1;
                    state_d        = HOLD;
                end else begin
                    cnt_d        = cnt_q + CNT_W'(1);
                    cpu_n_wait_d = 1'b0;
                end
            end
            HOLD: begin
                // Clear captured data on exit so nothing leaks into the next cycle
                if (cpu_n_rd) begin
                    cpu_rdata_d = 8'h00;
                    state_d     = IDLE;
                end else begin
                    cpu_rdata_en_d = 1'b1;
                end
            end
            DONE: begin
                if (cpu_n_rd && cpu_n_wr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpu_rdata    = cpu_rdata_q;
    assign cpu_rdata_en = cpu_rdata_en_q;
    assign cpu_n_wait   = cpu_n_wait_q;
    assign rom_n_cs     = rom_n_cs_q;
    assign rom_n_rd     = rom_n_rd_q;
    assign rom_address  = rom_address_q;
    assign io_n_cs      = io_n_cs_q;
    assign io_n_rd      = io_n_rd_q;
    assign io_n_wr      = io_n_wr_q;
    assign io_address   = io_address_q;
    assign io_wdata     = io_wdata_q;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Directed bench for cpu_bus_bridge: the bench plays CPU, ROM and I/O slave.
module tb_cpu_bus_bridge;

    logic        clk;
    logic        reset;
    logic        cpu_n_mreq, cpu_n_iorq, cpu_n_m1, cpu_n_rd, cpu_n_wr;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdata_en, cpu_n_wait;
    logic        rom_n_cs, rom_n_rd;
    logic [9:0]  rom_address;
    logic [7:0]  rom_rdata;
    logic        rom_rdata_en;
    logic        io_n_cs, io_n_rd, io_n_wr;
    logic [7:0]  io_address, io_wdata, io_rdata;
    logic        io_rdata_en;

    int checks = 0;
    int passed = 0;
    int rom_cnt = 0;
    int iord_cnt = 0;
    int iowr_cnt = 0;

    cpu_bus_bridge #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .cpu_n_mreq(cpu_n_mreq), .cpu_n_iorq(cpu_n_iorq), .cpu_n_m1(cpu_n_m1),
        .cpu_n_rd(cpu_n_rd), .cpu_n_wr(cpu_n_wr),
        .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_rdata_en(cpu_rdata_en), .cpu_n_wait(cpu_n_wait),
        .rom_n_cs(rom_n_cs), .rom_n_rd(rom_n_rd), .rom_address(rom_address),
        .rom_rdata(rom_rdata), .rom_rdata_en(rom_rdata_en),
        .io_n_cs(io_n_cs), .io_n_rd(io_n_rd), .io_n_wr(io_n_wr),
        .io_address(io_address), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_rdata_en(io_rdata_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count strobe-low clocks on each slave
    always @(negedge clk) begin
        if (!rom_n_cs && !rom_n_rd) rom_cnt <= rom_cnt + 1;
        if (!io_n_cs && !io_n_rd)   iord_cnt <= iord_cnt + 1;
        if (!io_n_cs && !io_n_wr)   iowr_cnt <= iowr_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        cpu_n_mreq = 1'b1; cpu_n_iorq = 1'b1; cpu_n_m1 = 1'b1;
        cpu_n_rd = 1'b1;   cpu_n_wr = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_idle();
        cpu_address = 16'h0; cpu_wdata = 8'h0;
        rom_rdata = 8'h0; rom_rdata_en = 1'b0; io_rdata = 8'h0; io_rdata_en = 1'b0;
        tick(); tick();
        checks++; if ({rom_n_cs, rom_n_rd, io_n_cs, io_n_rd, io_n_wr, cpu_n_wait} !== 6'b111111)
            $display("FAIL reset_strobes: got %b want 111111", {rom_n_cs, rom_n_rd, io_n_cs, io_n_rd, io_n_wr, cpu_n_wait}); else passed++;
        checks++; if ({rom_address, io_address, io_wdata, cpu_rdata, cpu_rdata_en} !== 35'd0)
            $display("FAIL reset_data: got %h want 0", {rom_address, io_address, io_wdata, cpu_rdata, cpu_rdata_en}); else passed++;
        reset = 1'b0;
        tick(); tick();
    endtask

    task automatic test_rom_read();
        int c0 = rom_cnt;
        cpu_n_mreq = 1'b0; cpu_n_rd = 1'b0; cpu_address = 16'h0001;
        tick();
        checks++; if ({rom_n_cs, rom_n_rd, cpu_n_wait} !== 3'b000)
            $display("FAIL rom_strobe: got %b want 000", {rom_n_cs, rom_n_rd, cpu_n_wait}); else passed++;
        checks++; if (rom_address !== 10'h001) $display("FAIL rom_addr: got %h want 001", rom_address); else passed++;
        tick();
        checks++; if ({rom_n_cs, cpu_n_wait} !== 2'b10) $display("FAIL rom_e1: got %b want 10", {rom_n_cs, cpu_n_wait}); else passed++;
        rom_rdata_en = 1'b1; rom_rdata = 8'h31;
        tick();
        rom_rdata_en = 1'b0; rom_rdata = 8'h00;
        checks++; if ({cpu_rdata, cpu_rdata_en, cpu_n_wait} !== {8'h31, 2'b11})
            $display("FAIL rom_data: got %h/%b/%b want 31/1/1", cpu_rdata, cpu_rdata_en, cpu_n_wait); else passed++;
        tick();
        checks++; if (cpu_rdata_en !== 1'b1) $display("FAIL rom_hold: got %b want 1", cpu_rdata_en); else passed++;
        bus_idle();
        tick();
        checks++; if (cpu_rdata_en !== 1'b0) $display("FAIL rom_release: got %b want 0", cpu_rdata_en); else passed++;
        checks++; if (rom_cnt - c0 !== 1) $display("FAIL rom_pulse_len: got %0d want 1", rom_cnt - c0); else passed++;
    endtask

    task automatic test_io_write_read();
        int w0 = iowr_cnt;
        int r0 = iord_cnt;
        int early = 0;
        cpu_n_iorq = 1'b0; cpu_n_wr = 1'b0; cpu_address = 16'h1220; cpu_wdata = 8'hF5;
        tick();
        checks++; if ({io_n_cs, io_n_wr, io_n_rd, cpu_n_wait} !== 4'b0011)
            $display("FAIL iowr_strobe: got %b want 0011", {io_n_cs, io_n_wr, io_n_rd, cpu_n_wait}); else passed++;
        checks++; if ({io_address, io_wdata} !== 16'h20F5)
            $display("FAIL iowr_payload: got %h want 20F5", {io_address, io_wdata}); else passed++;
        tick(); tick();
        bus_idle();
        tick();
        checks++; if (iowr_cnt - w0 !== 1) $display("FAIL iowr_count: got %0d want 1", iowr_cnt - w0); else passed++;
        cpu_n_iorq = 1'b0; cpu_n_rd = 1'b0; cpu_address = 16'h0010;
        tick();
        checks++; if ({io_n_cs, io_n_rd, io_address, cpu_n_wait} !== {2'b00, 8'h10, 1'b0})
            $display("FAIL iord_strobe: got %b %b %h %b want 0 0 10 0", io_n_cs, io_n_rd, io_address, cpu_n_wait); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cpu_n_wait !== 1'b0 || cpu_rdata_en !== 1'b0) early++;
        end
        checks++; if (early !== 0) $display("FAIL iord_wait_held: got %0d early releases want 0", early); else passed++;
        io_rdata_en = 1'b1; io_rdata = 8'h5A;
        tick();
        io_rdata_en = 1'b0; io_rdata = 8'h00;
        checks++; if ({cpu_rdata, cpu_rdata_en, cpu_n_wait} !== {8'h5A, 2'b11})
            $display("FAIL iord_data: got %h/%b/%b want 5A/1/1", cpu_rdata, cpu_rdata_en, cpu_n_wait); else passed++;
        bus_idle();
        tick();
        checks++; if (iord_cnt - r0 !== 1) $display("FAIL iord_count: got %0d want 1", iord_cnt - r0); else passed++;
    endtask

    task automatic test_timeout_unmapped();
        int early = 0;
        int c0 = rom_cnt;
        cpu_n_iorq = 1'b0; cpu_n_rd = 1'b0; cpu_address = 16'h0030;
        tick();
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (cpu_rdata_en !== 1'b0 || cpu_n_wait !== 1'b0) early++;
        end
        checks++; if (early !== 0) $display("FAIL timeout_early: got %0d early completions want 0", early); else passed++;
        tick();
        checks++; if ({cpu_rdata, cpu_rdata_en, cpu_n_wait} !== {8'hFF, 2'b11})
            $display("FAIL timeout_data: got %h/%b/%b want FF/1/1", cpu_rdata, cpu_rdata_en, cpu_n_wait); else passed++;
        bus_idle();
        tick();
        cpu_n_mreq = 1'b0; cpu_n_rd = 1'b0; cpu_address = 16'h8000;
        tick();
        checks++; if ({cpu_rdata, cpu_rdata_en, cpu_n_wait} !== {8'hFF, 2'b11})
            $display("FAIL unmapped_data: got %h/%b/%b want FF/1/1", cpu_rdata, cpu_rdata_en, cpu_n_wait); else passed++;
        bus_idle();
        tick();
        checks++; if (rom_cnt !== c0) $display("FAIL unmapped_no_strobe: got %0d want %0d", rom_cnt, c0); else passed++;
    endtask

    task automatic test_ignored();
        int r0 = rom_cnt;
        int i0 = iord_cnt + iowr_cnt;
        cpu_n_mreq = 1'b0; cpu_address = 16'h0005;
        tick(); tick();
        checks++; if ({cpu_n_wait, cpu_rdata_en} !== 2'b10) $display("FAIL refresh: got %b want 10", {cpu_n_wait, cpu_rdata_en}); else passed++;
        bus_idle();
        tick();
        cpu_n_mreq = 1'b0; cpu_n_wr = 1'b0; cpu_wdata = 8'hAA;
        tick();
        checks++; if ({cpu_n_wait, cpu_rdata_en} !== 2'b10) $display("FAIL memwrite: got %b want 10", {cpu_n_wait, cpu_rdata_en}); else passed++;
        bus_idle();
        tick();
        cpu_n_iorq = 1'b0; cpu_n_m1 = 1'b0;
        tick();
        checks++; if ({cpu_rdata, cpu_rdata_en, cpu_n_wait} !== {8'hFF, 2'b11})
            $display("FAIL intack_data: got %h/%b/%b want FF/1/1", cpu_rdata, cpu_rdata_en, cpu_n_wait); else passed++;
        bus_idle();
        tick();
        checks++; if (rom_cnt - r0 + iord_cnt + iowr_cnt - i0 !== 0)
            $display("FAIL ignored_strobes: got %0d want 0", rom_cnt - r0 + iord_cnt + iowr_cnt - i0); else passed++;
    endtask

    task automatic test_reset_midcycle();
        int c0;
        cpu_n_mreq = 1'b0; cpu_n_rd = 1'b0; cpu_address = 16'h0001;
        tick(); tick();
        reset = 1'b1;
        tick();
        checks++; if ({rom_n_cs, rom_n_rd, io_n_cs, io_n_rd, io_n_wr, cpu_n_wait} !== 6'b111111)
            $display("FAIL midreset_strobes: got %b want 111111", {rom_n_cs, rom_n_rd, io_n_cs, io_n_rd, io_n_wr, cpu_n_wait}); else passed++;
        checks++; if ({rom_address, io_address, io_wdata, cpu_rdata, cpu_rdata_en} !== 35'd0)
            $display("FAIL midreset_data: got %h want 0", {rom_address, io_address, io_wdata, cpu_rdata, cpu_rdata_en}); else passed++;
        reset = 1'b0;
        c0 = rom_cnt;
        tick(); tick(); tick();
        checks++; if (rom_cnt !== c0 || rom_n_cs !== 1'b1)
            $display("FAIL unarmed_strobe: got %0d strobes want 0", rom_cnt - c0); else passed++;
        bus_idle();
        tick();
    endtask

    task automatic test_back_to_back();
        int c0 = rom_cnt;
        cpu_n_mreq = 1'b0; cpu_n_rd = 1'b0; cpu_address = 16'h0000;
        tick();
        checks++; if ({rom_n_cs, rom_address} !== {1'b0, 10'h000}) $display("FAIL b2b_strobe0: got %b %h want 0 000", rom_n_cs, rom_address); else passed++;
        tick();
        rom_rdata_en = 1'b1; rom_rdata = 8'hF3;
        tick();
        rom_rdata_en = 1'b0; rom_rdata = 8'h00;
        checks++; if ({cpu_rdata, cpu_rdata_en} !== {8'hF3, 1'b1}) $display("FAIL b2b_data0: got %h/%b want F3/1", cpu_rdata, cpu_rdata_en); else passed++;
        bus_idle();
        tick();
        checks++; if ({cpu_rdata, cpu_rdata_en} !== 9'd0) $display("FAIL b2b_idle_clear: got %h/%b want 00/0", cpu_rdata, cpu_rdata_en); else passed++;
        cpu_n_mreq = 1'b0; cpu_n_rd = 1'b0; cpu_address = 16'h0001;
        tick();
        checks++; if ({rom_n_cs, rom_address} !== {1'b0, 10'h001}) $display("FAIL b2b_strobe1: got %b %h want 0 001", rom_n_cs, rom_address); else passed++;
        tick();
        checks++; if ({cpu_rdata, cpu_rdata_en} !== 9'd0) $display("FAIL b2b_carry: got %h/%b want 00/0", cpu_rdata, cpu_rdata_en); else passed++;
        rom_rdata_en = 1'b1; rom_rdata = 8'h31;
        tick();
        rom_rdata_en = 1'b0; rom_rdata = 8'h00;
        checks++; if ({cpu_rdata, cpu_rdata_en} !== {8'h31, 1'b1}) $display("FAIL b2b_data1: got %h/%b want 31/1", cpu_rdata, cpu_rdata_en); else passed++;
        bus_idle();
        tick();
        checks++; if (rom_cnt - c0 !== 2) $display("FAIL b2b_count: got %0d want 2", rom_cnt - c0); else passed++;
    endtask

    initial begin
        test_reset();
        test_rom_read();
        test_io_write_read();
        test_timeout_unmapped();
        test_ignored();
        test_reset_midcycle();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
